antares_hilo_muldiv: RTL and testbench

//  Parametrised HI/LO multiply-divide unit for the EX stage: iterative multiplier (MUL_BPC bits/cycle),

---
 rtl/antares_hilo_muldiv_pkg.sv | 59 +++++
 rtl/antares_hilo_muldiv_if.sv | 31 +++
 rtl/antares_muldiv_core.sv | 82 ++++++++
 rtl/antares_hilo_muldiv.sv | 149 ++++++++++++++
 tb/tb_antares_hilo_muldiv.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/antares_hilo_muldiv_pkg.sv
// Shared definitions for the HI/LO multiply-divide unit.
//   md_op_e    : 4-bit operation codes presented on md_op
//   md_state_e : control FSM state encodings
//   acc_kind_e : how the FIX step combines its result with HI/LO
// Helper functions classify an opcode so that the top and the bench agree
// on which ops iterate, which are signed and how they accumulate.
package antares_hilo_muldiv_pkg;

    typedef enum logic [3:0] {
        MD_OP_NONE  = 4'd0,
        MD_OP_MULT  = 4'd1,
        MD_OP_MULTU = 4'd2,
        MD_OP_MADD  = 4'd3,
        MD_OP_MADDU = 4'd4,
        MD_OP_MSUB  = 4'd5,
        MD_OP_MSUBU = 4'd6,
        MD_OP_DIV   = 4'd7,
        MD_OP_DIVU  = 4'd8,
        MD_OP_MTHI  = 4'd9,
        MD_OP_MTLO  = 4'd10,
        MD_OP_MFHI  = 4'd11,
        MD_OP_MFLO  = 4'd12
    } md_op_e;

    typedef enum logic [1:0] {
        MD_ST_IDLE = 2'd0,
        MD_ST_MUL  = 2'd1,
        MD_ST_DIV  = 2'd2,
        MD_ST_FIX  = 2'd3
    } md_state_e;

    typedef enum logic [1:0] {
        ACC_SET = 2'd0,
        ACC_ADD = 2'd1,
        ACC_SUB = 2'd2
    } acc_kind_e;

    function automatic logic is_mul_op(input md_op_e op);
        return op inside {MD_OP_MULT, MD_OP_MULTU, MD_OP_MADD, MD_OP_MADDU,
                          MD_OP_MSUB, MD_OP_MSUBU};
    endfunction

    function automatic logic is_div_op(input md_op_e op);
        return op inside {MD_OP_DIV, MD_OP_DIVU};
    endfunction

    function automatic logic is_signed_op(input md_op_e op);
        return op inside {MD_OP_MULT, MD_OP_MADD, MD_OP_MSUB, MD_OP_DIV};
    endfunction

    function automatic acc_kind_e acc_kind_of(input md_op_e op);
        acc_kind_e k;
        k = ACC_SET;
        if (op inside {MD_OP_MADD, MD_OP_MADDU}) k = ACC_ADD;
        if (op inside {MD_OP_MSUB, MD_OP_MSUBU}) k = ACC_SUB;
        return k;
    endfunction

endpackage

// File: rtl/antares_hilo_muldiv_if.sv
// EX-stage <-> multiply/divide unit bundle.
//   master : EX stage (drives op/enable/flush/operands, observes stall/busy/data)
//   slave  : the HI/LO unit
// Signals: md_op, md_enable, md_flush, md_port_a, md_port_b (requests);
//          md_request_stall, md_busy, md_read_data, md_hi, md_lo (responses).
interface antares_hilo_muldiv_if #(
    parameter int XLEN = 32
);
    import antares_hilo_muldiv_pkg::*;

    md_op_e            md_op;
    logic              md_enable;
    logic              md_flush;
    logic [XLEN-1:0]   md_port_a;
    logic [XLEN-1:0]   md_port_b;
    logic              md_request_stall;
    logic              md_busy;
    logic [XLEN-1:0]   md_read_data;
    logic [XLEN-1:0]   md_hi;
    logic [XLEN-1:0]   md_lo;

    modport master (
        output md_op, md_enable, md_flush, md_port_a, md_port_b,
        input  md_request_stall, md_busy, md_read_data, md_hi, md_lo
    );

    modport slave (
        input  md_op, md_enable, md_flush, md_port_a, md_port_b,
        output md_request_stall, md_busy, md_read_data, md_hi, md_lo
    );
endinterface

// File: rtl/antares_muldiv_core.sv
// Iterative multiply / divide datapath (unsigned magnitudes only).
//   clk, rst      : clock, async active-low reset
//   start         : load operands and iteration count (is_div selects mode)
//   step          : perform one iteration while the count is non-zero
//   a_abs, b_abs  : operand magnitudes
//   last          : the current step is the final one
//   acc           : multiply -> 2*XLEN product; divide -> {remainder, quotient}
// Multiply shifts the multiplicand left and adds a*b[MUL_BPC-1:0] each step.
// Divide is restoring: remainder/quotient share acc and shift left together.
module antares_muldiv_core #(
    parameter int XLEN    = 32,
    parameter int MUL_BPC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              is_div,
    input  logic              step,
    input  logic [XLEN-1:0]   a_abs,
    input  logic [XLEN-1:0]   b_abs,
    output logic              last,
    output logic [2*XLEN-1:0] acc
);
    localparam int CW = $clog2(XLEN + 1);
    localparam logic [CW-1:0] MUL_ITERS = CW'(XLEN / MUL_BPC);
    localparam logic [CW-1:0] DIV_ITERS = CW'(XLEN);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    logic [2*XLEN-1:0] acc_q;
    logic [2*XLEN-1:0] opnd_q;   // multiplicand (shifting) or divisor (low half)
    logic [XLEN-1:0]   mplr_q;
    logic [CW-1:0]     cnt_q;
    logic              div_mode_q;

    logic [2*XLEN-1:0] pp;
    logic [2*XLEN-1:0] acc_mul;
    logic [XLEN:0]     shifted;
    logic [XLEN:0]     trial;
    logic              q_bit;
    logic [XLEN-1:0]   rem_n;
    logic [2*XLEN-1:0] acc_div;

    assign pp      = opnd_q * {{(2*XLEN-MUL_BPC){1'b0}}, mplr_q[MUL_BPC-1:0]};
    assign acc_mul = acc_q + pp;

    // Remainder stays below the divisor, so the shifted value fits XLEN+1
    // bits and the top bit of the trial difference is the borrow.
    assign shifted = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    assign trial   = shifted - {1'b0, opnd_q[XLEN-1:0]};
    assign q_bit   = ~trial[XLEN];
    assign rem_n   = q_bit ? trial[XLEN-1:0] : shifted[XLEN-1:0];
    assign acc_div = {rem_n, acc_q[XLEN-2:0], q_bit};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q      <= '0;
            opnd_q     <= '0;
            mplr_q     <= '0;
            cnt_q      <= '0;
            div_mode_q <= 1'b0;
        end else if (start) begin
            div_mode_q <= is_div;
            cnt_q      <= is_div ? DIV_ITERS : MUL_ITERS;
            acc_q      <= is_div ? {{XLEN{1'b0}}, a_abs} : '0;
            opnd_q     <= {{XLEN{1'b0}}, (is_div ? b_abs : a_abs)};
            mplr_q     <= b_abs;
        end else if (step && cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_ONE;
            if (div_mode_q) begin
                acc_q <= acc_div;
            end else begin
                acc_q  <= acc_mul;
                opnd_q <= opnd_q << MUL_BPC;
                mplr_q <= mplr_q >> MUL_BPC;
            end
        end
    end

    assign last = (cnt_q == CNT_ONE);
    assign acc  = acc_q;

endmodule

// File: rtl/antares_hilo_muldiv.sv
// HI/LO multiply-divide unit for the EX stage.
//   clk, rst : clock, async active-low reset
//   md       : slave side of antares_hilo_muldiv_if (op/enable/flush/operands
//              in; stall/busy/read data/HI/LO out)
// MULT*/MADD*/MSUB* and DIV* run in the background on antares_muldiv_core;
// the FIX state applies signs and writes HI/LO. Any HI/LO op arriving while
// busy stalls EX. Flush aborts without touching HI/LO.
module antares_hilo_muldiv
    import antares_hilo_muldiv_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int MUL_BPC = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    antares_hilo_muldiv_if.slave md
);
    if ((XLEN % 2) != 0 || XLEN < 8 || (MUL_BPC != 1 && MUL_BPC != 2 && MUL_BPC != 4)
        || (XLEN % MUL_BPC) != 0) begin : g_bad_param
        $error("antares_hilo_muldiv: unsupported XLEN/MUL_BPC");
    end

    md_state_e         state_q, state_d;
    logic [XLEN-1:0]   hi_q, lo_q;
    logic              neg_res_q, neg_rem_q, div_q;
    acc_kind_e         kind_q;

    logic              hilo_op, busy, issue_ok;
    logic              start_mul, div_op, b_zero, start_div, div_zero, fix_write;
    logic              sgn, a_neg, b_neg;
    logic [XLEN-1:0]   a_abs, b_abs;
    logic              core_last;
    logic [2*XLEN-1:0] core_acc;

    logic [XLEN-1:0]   raw_hi, raw_lo, neg_hi, neg_lo, fix_hi, fix_lo;
    logic [2*XLEN-1:0] base, addend, sum;
    logic              sub;

    // ---------------- issue decode ----------------
    assign hilo_op   = (md.md_op != MD_OP_NONE);
    assign busy      = (state_q != MD_ST_IDLE);
    assign issue_ok  = (state_q == MD_ST_IDLE) & md.md_enable & ~md.md_flush;
    assign start_mul = issue_ok & is_mul_op(md.md_op);
    assign div_op    = issue_ok & is_div_op(md.md_op);
    assign b_zero    = (md.md_port_b == '0);
    assign start_div = div_op & ~b_zero;
    assign div_zero  = div_op & b_zero;

    assign sgn   = is_signed_op(md.md_op);
    assign a_neg = sgn & md.md_port_a[XLEN-1];
    assign b_neg = sgn & md.md_port_b[XLEN-1];
    assign a_abs = a_neg ? -md.md_port_a : md.md_port_a;
    assign b_abs = b_neg ? -md.md_port_b : md.md_port_b;

    antares_muldiv_core #(
        .XLEN    (XLEN),
        .MUL_BPC (MUL_BPC)
    ) u_core (
        .clk    (clk),
        .rst    (rst),
        .start  (start_mul | start_div),
        .is_div (is_div_op(md.md_op)),
        .step   (state_q == MD_ST_MUL || state_q == MD_ST_DIV),
        .a_abs  (a_abs),
        .b_abs  (b_abs),
        .last   (core_last),
        .acc    (core_acc)
    );

    // ---------------- control FSM ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= MD_ST_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            MD_ST_IDLE: begin
                if (start_mul)      state_d = MD_ST_MUL;
                else if (start_div) state_d = MD_ST_DIV;
            end
            MD_ST_MUL, MD_ST_DIV: begin
                if (md.md_flush)    state_d = MD_ST_IDLE;
                else if (core_last) state_d = MD_ST_FIX;
            end
            MD_ST_FIX: state_d = MD_ST_IDLE;
            default:   state_d = MD_ST_IDLE;
        endcase
    end

    // Sign/kind captured at issue; the operands themselves live in the core.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div_q     <= 1'b0;
            kind_q    <= ACC_SET;
        end else if (start_mul | start_div) begin
            neg_res_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            div_q     <= start_div;
            kind_q    <= acc_kind_of(md.md_op);
        end
    end

    // ---------------- FIX: sign fixup + accumulate ----------------
    // One negator serves both paths: a 2*XLEN negate is {~hi + (lo==0), -lo},
    // and the divider's independent remainder negate is ~hi + 1.
    assign raw_hi = core_acc[2*XLEN-1:XLEN];
    assign raw_lo = core_acc[XLEN-1:0];
    assign neg_lo = -raw_lo;
    assign neg_hi = ~raw_hi + {{(XLEN-1){1'b0}}, (div_q | (raw_lo == '0))};
    assign fix_lo = neg_res_q ? neg_lo : raw_lo;
    assign fix_hi = (div_q ? neg_rem_q : neg_res_q) ? neg_hi : raw_hi;

    // Single adder: set (base 0), add, or subtract via invert + carry-in.
    assign sub    = (kind_q == ACC_SUB);
    assign base   = (kind_q == ACC_SET) ? '0 : {hi_q, lo_q};
    assign addend = {fix_hi, fix_lo} ^ {(2*XLEN){sub}};
    assign sum    = base + addend + {{(2*XLEN-1){1'b0}}, sub};

    assign fix_write = (state_q == MD_ST_FIX) & ~md.md_flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (fix_write) begin
            {hi_q, lo_q} <= sum;
        end else if (div_zero) begin
            hi_q <= md.md_port_a;
            lo_q <= '1;
        end else if (issue_ok && md.md_op == MD_OP_MTHI) begin
            hi_q <= md.md_port_a;
        end else if (issue_ok && md.md_op == MD_OP_MTLO) begin
            lo_q <= md.md_port_a;
        end
    end

    // ---------------- outputs ----------------
    assign md.md_busy          = busy;
    assign md.md_request_stall = busy & hilo_op;
    assign md.md_read_data     = (md.md_op == MD_OP_MFHI) ? hi_q :
                                 (md.md_op == MD_OP_MFLO) ? lo_q : '0;
    assign md.md_hi            = hi_q;
    assign md.md_lo            = lo_q;

endmodule

// File: tb/tb_antares_hilo_muldiv.sv
// Scoreboard bench for antares_hilo_muldiv (XLEN=32, MUL_BPC=2).
// Iterative ops push {HI, LO, busy-cycles} on issue; a monitor pops and
// compares on the negedge where md_busy falls.
module tb_antares_hilo_muldiv;
    import antares_hilo_muldiv_pkg::*;

    typedef struct {
        string       tag;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } sb_t;

    logic clk;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;
    sb_t  sb[$];
    logic [63:0] m_hl;

    antares_hilo_muldiv_if #(.XLEN(32)) md ();

    antares_hilo_muldiv #(.XLEN(32), .MUL_BPC(2)) dut (
        .clk (clk),
        .rst (rst),
        .md  (md)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input md_op_e op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] hl);
        longint      sa, sb_, q, r;
        logic [63:0] ua, ub, sp, up, qv, rv, res;
        sa = longint'($signed(a));
        sb_ = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        sp = sa * sb_;
        up = ua * ub;
        res = hl;
        case (op)
            MD_OP_MULT:  res = sp;
            MD_OP_MULTU: res = up;
            MD_OP_MADD:  res = hl + sp;
            MD_OP_MADDU: res = hl + up;
            MD_OP_MSUB:  res = hl - sp;
            MD_OP_MSUBU: res = hl - up;
            MD_OP_DIV, MD_OP_DIVU: begin
                if (b == 32'd0) begin
                    res = {a, 32'hFFFF_FFFF};
                end else begin
                    if (op == MD_OP_DIV) begin
                        q = sa / sb_;
                        r = sa % sb_;
                        qv = q;
                        rv = r;
                    end else begin
                        qv = ua / ub;
                        rv = ua % ub;
                    end
                    res = {rv[31:0], qv[31:0]};
                end
            end
            MD_OP_MTHI: res = {a, hl[31:0]};
            MD_OP_MTLO: res = {hl[63:32], a};
            default:    res = hl;
        endcase
        return res;
    endfunction

    task automatic drive(input md_op_e op, input logic [31:0] a, input logic [31:0] b);
        md.md_op     = op;
        md.md_enable = 1'b1;
        md.md_port_a = a;
        md.md_port_b = b;
        @(posedge clk);
        #1;
        md.md_op     = MD_OP_NONE;
        md.md_enable = 1'b0;
    endtask

    task automatic issue(input md_op_e op, input logic [31:0] a, input logic [31:0] b,
                         input string tag);
        sb_t         e;
        logic [63:0] nx;
        nx = model(op, a, b, m_hl);
        if (is_mul_op(op) || (is_div_op(op) && b != 32'd0)) begin
            e.tag = tag;
            e.hi  = nx[63:32];
            e.lo  = nx[31:0];
            e.lat = is_div_op(op) ? 33 : 17;
            sb.push_back(e);
        end
        m_hl = nx;
        drive(op, a, b);
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " drain"}, 64'(sb.size()), 64'd0);
    endtask

    // Monitor: count busy cycles, compare HI/LO when busy falls.
    initial begin
        logic prev_busy;
        int   busy_cnt;
        sb_t  e;
        prev_busy = 1'b0;
        busy_cnt  = 0;
        forever begin
            @(negedge clk);
            if (md.md_busy === 1'b1) begin
                busy_cnt++;
            end else begin
                if (prev_busy && sb.size() > 0) begin
                    e = sb.pop_front();
                    chk({e.tag, " hi"},  {32'd0, md.md_hi}, {32'd0, e.hi});
                    chk({e.tag, " lo"},  {32'd0, md.md_lo}, {32'd0, e.lo});
                    chk({e.tag, " lat"}, 64'(busy_cnt), 64'(e.lat));
                end
                busy_cnt = 0;
            end
            prev_busy = md.md_busy;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        md_op_e      rops[6];
        sb_t         e;
        md_op_e      rop;
        logic [31:0] ra, rb;
        int          g;

        rops = '{MD_OP_MULT, MD_OP_MULTU, MD_OP_MADD, MD_OP_MSUB, MD_OP_DIV, MD_OP_DIVU};
        m_hl         = 64'd0;
        rst          = 1'b0;
        md.md_op     = MD_OP_NONE;
        md.md_enable = 1'b0;
        md.md_flush  = 1'b0;
        md.md_port_a = '0;
        md.md_port_b = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst busy",  64'(md.md_busy), 64'd0);
        chk("rst stall", 64'(md.md_request_stall), 64'd0);
        chk("rst hi",    64'(md.md_hi), 64'd0);
        chk("rst lo",    64'(md.md_lo), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Directed cases
        issue(MD_OP_MULT, 32'hFFFF_FFFD, 32'd7, "mult -3*7");
        wait_done("mult");
        @(posedge clk); #1;

        issue(MD_OP_MTHI, 32'd0, 32'd0, "mthi");
        chk("mthi hi", 64'(md.md_hi), 64'(m_hl[63:32]));
        issue(MD_OP_MTLO, 32'd10, 32'd0, "mtlo");
        chk("mtlo lo", 64'(md.md_lo), 64'(m_hl[31:0]));

        issue(MD_OP_MADDU, 32'hFFFF_FFFF, 32'd2, "maddu");
        wait_done("maddu");
        @(posedge clk); #1;
        issue(MD_OP_MSUBU, 32'hFFFF_FFFF, 32'd2, "msubu");
        wait_done("msubu");
        @(posedge clk); #1;

        md.md_op = MD_OP_MFHI; #1;
        chk("mfhi data", 64'(md.md_read_data), 64'(m_hl[63:32]));
        md.md_op = MD_OP_MFLO; #1;
        chk("mflo data", 64'(md.md_read_data), 64'(m_hl[31:0]));
        md.md_op = MD_OP_NONE; #1;
        chk("none data", 64'(md.md_read_data), 64'd0);
        @(posedge clk); #1;

        issue(MD_OP_DIV, 32'hFFFF_FFF9, 32'd2, "div -7/2");
        wait_done("div");
        @(posedge clk); #1;
        issue(MD_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div min/-1");
        wait_done("divmin");
        @(posedge clk); #1;

        issue(MD_OP_DIVU, 32'd5, 32'd0, "divu /0");
        chk("div0 busy", 64'(md.md_busy), 64'd0);
        chk("div0 hi",   64'(md.md_hi), 64'(m_hl[63:32]));
        chk("div0 lo",   64'(md.md_lo), 64'(m_hl[31:0]));
        @(negedge clk);
        chk("div0 busy2", 64'(md.md_busy), 64'd0);
        @(posedge clk); #1;

        // Stall: ADD (non-HILO) passes, MFLO stalls until the write lands.
        issue(MD_OP_MULT, 32'd1234, 32'hFFFF_FFFB, "mult stall");
        md.md_op = MD_OP_NONE;
        md.md_enable = 1'b1;
        #2;
        chk("add nostall", 64'(md.md_request_stall), 64'd0);
        chk("add busy",    64'(md.md_busy), 64'd1);
        @(posedge clk); #1;
        md.md_op = MD_OP_MFLO;
        @(negedge clk);
        chk("mflo stall", 64'(md.md_request_stall), 64'd1);
        g = 0;
        while (md.md_request_stall && g < 100) begin
            @(negedge clk);
            g++;
        end
        chk("mflo release", 64'(md.md_request_stall), 64'd0);
        chk("mflo product", 64'(md.md_read_data), 64'(m_hl[31:0]));
        md.md_op = MD_OP_NONE;
        md.md_enable = 1'b0;
        wait_done("stall");
        @(posedge clk); #1;

        // Random mix
        for (int i = 0; i < 10; i++) begin
            rop = rops[$urandom_range(0, 5)];
            ra  = $urandom;
            rb  = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(1, 300));
            if ($urandom_range(0, 1) == 1) rb = -rb;
            if (rb == 32'd0) rb = 32'd3;
            issue(rop, ra, rb, $sformatf("rnd%0d op%0d", i, rop));
            wait_done("rnd");
            @(posedge clk); #1;
        end

        // Flush during the issue cycle blocks the issue.
        md.md_flush = 1'b1;
        drive(MD_OP_MULT, 32'd9, 32'd9);
        md.md_flush = 1'b0;
        chk("flush issue busy", 64'(md.md_busy), 64'd0);
        @(negedge clk);
        chk("flush issue hilo", {md.md_hi, md.md_lo}, m_hl);
        @(posedge clk); #1;

        // Flush after 5 divide iterations: HI/LO keep pre-issue values.
        e.tag = "div flush";
        e.hi  = m_hl[63:32];
        e.lo  = m_hl[31:0];
        e.lat = 6;
        sb.push_back(e);
        drive(MD_OP_DIV, 32'd100, 32'd3);
        repeat (5) @(posedge clk);
        #1;
        md.md_flush = 1'b1;
        @(posedge clk);
        #1;
        md.md_flush = 1'b0;
        chk("flush busy", 64'(md.md_busy), 64'd0);
        wait_done("flush");
        @(posedge clk); #1;

        // Async reset mid-multiply.
        issue(MD_OP_MTHI, 32'hDEAD_BEEF, 32'd0, "mthi pre");
        e.tag = "rst mul";
        e.hi  = 32'd0;
        e.lo  = 32'd0;
        e.lat = 4;
        sb.push_back(e);
        drive(MD_OP_MULTU, 32'd77, 32'd88);
        repeat (4) @(posedge clk);
        #4;
        rst  = 1'b0;
        m_hl = 64'd0;
        #1;
        chk("rst mid busy", 64'(md.md_busy), 64'd0);
        chk("rst mid hilo", {md.md_hi, md.md_lo}, 64'd0);
        wait_done("rst");
        #2;
        rst = 1'b1;
        @(posedge clk); #1;
        issue(MD_OP_MULTU, 32'd6, 32'd7, "post rst");
        wait_done("post rst");

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
